// File: rtl/comparador_sequencial_if.sv
// comparador_sequencial_if: user-side bus of the sequential code checker.
// The user (master) drives the digit stream and the secret. The checker
// (slave) returns its position, the attempt count and the status flags.
`timescale 1ns/1ps
interface comparador_sequencial_if #(
    parameter int WIDTH    = 3,
    parameter int DIGITS   = 4,
    parameter int MAX_TENT = 3
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(MAX_TENT + 1);

    logic                    habilita;
    logic [WIDTH-1:0]        digito;
    logic                    digito_valido;
    logic                    limpar;
    logic [DIGITS*WIDTH-1:0] segredo;

    logic [IW-1:0]           indice;
    logic [TW-1:0]           tentativas;
    logic                    acerto;
    logic                    erro;
    logic                    desarmado;
    logic                    bloqueado;

    modport master (
        output habilita, digito, digito_valido, limpar, segredo,
        input  indice, tentativas, acerto, erro, desarmado, bloqueado
    );

    modport slave (
        input  habilita, digito, digito_valido, limpar, segredo,
        output indice, tentativas, acerto, erro, desarmado, bloqueado
    );
endinterface

// File: rtl/comparador_sequencial.sv
// comparador_sequencial: checks a code entered one digit at a time against a
// secret. It produces one acerto/erro pulse per complete attempt. A correct
// code disarms the block, and MAX_TENT failed attempts lock it. Both terminal
// states stay in force until reset.
// Optional build macro COMPARADOR_TIMEOUT_DIGITO_EN: a partial attempt left
// idle for TIMEOUT_CICLOS cycles counts as a failed attempt.
`timescale 1ns/1ps
module comparador_sequencial #(
    parameter int WIDTH          = 3,
    parameter int DIGITS         = 4,
    parameter int MAX_TENT       = 3,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comparador_sequencial_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(MAX_TENT + 1);

    typedef enum logic [1:0] {
        ENTRADA   = 2'd0,
        RESULTADO = 2'd1,
        DESARMADO = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    estado_t       r_estado, w_estado_prox;
    logic [IW-1:0] r_indice, w_indice_prox;
    logic [TW-1:0] r_tent,   w_tent_prox;
    // r_falha is sticky: it records any mismatch seen in the current attempt.
    logic          r_falha,  w_falha_prox;

    logic             w_aceita;
    logic             w_dif;
    logic [WIDTH-1:0] w_dig_segredo;

`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0] r_cnt, w_cnt_prox;
`else
    // Without the timeout feature, this parameter only exists to keep the
    // same port list. No logic is built from it.
    localparam int unused_timeout_ciclos = TIMEOUT_CICLOS;
`endif

    // Digit qualification and comparison against the expected secret digit.
    always_comb begin
        w_aceita      = bus.habilita && bus.digito_valido && !bus.limpar;
        w_dig_segredo = bus.segredo[int'(r_indice)*WIDTH +: WIDTH];
        w_dif         = (bus.digito != w_dig_segredo);
    end

    // State register. The reset forces a fresh, empty attempt, even from a
    // terminal state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= ENTRADA;
            r_indice <= '0;
            r_tent   <= '0;
            r_falha  <= 1'b0;
`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
            r_cnt    <= '0;
`endif
        end else begin
            r_estado <= w_estado_prox;
            r_indice <= w_indice_prox;
            r_tent   <= w_tent_prox;
            r_falha  <= w_falha_prox;
`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
            r_cnt    <= w_cnt_prox;
`endif
        end
    end

    // Next-state logic: digit entry, attempt scoring and terminal states.
    always_comb begin
        w_estado_prox = r_estado;
        w_indice_prox = r_indice;
        w_tent_prox   = r_tent;
        w_falha_prox  = r_falha;
`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
        w_cnt_prox    = r_cnt;
`endif
        case (r_estado)
            ENTRADA: begin
                if (bus.limpar) begin
                    // limpar beats a simultaneous strobe, and the attempt
                    // count is kept.
                    w_indice_prox = '0;
                    w_falha_prox  = 1'b0;
`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
                    w_cnt_prox    = '0;
`endif
                end else if (w_aceita) begin
                    w_falha_prox = r_falha || w_dif;
`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
                    w_cnt_prox   = '0;
`endif
                    if (r_indice == IW'(DIGITS - 1)) begin
                        // Last digit: score the attempt at this same edge.
                        w_indice_prox = '0;
                        w_estado_prox = RESULTADO;
                        if (r_falha || w_dif)
                            w_tent_prox = r_tent + TW'(1);
                    end else begin
                        w_indice_prox = r_indice + IW'(1);
                    end
                end
`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
                else if (r_indice != '0) begin
                    // An idle partial attempt expires into a failed attempt.
                    if (r_cnt == CW'(TIMEOUT_CICLOS - 1)) begin
                        w_cnt_prox    = '0;
                        w_indice_prox = '0;
                        w_falha_prox  = 1'b1;
                        w_tent_prox   = r_tent + TW'(1);
                        w_estado_prox = RESULTADO;
                    end else begin
                        w_cnt_prox = r_cnt + CW'(1);
                    end
                end
`endif
            end
            RESULTADO: begin
                // Single pulse cycle. All inputs are ignored here.
                if (!r_falha)
                    w_estado_prox = DESARMADO;
                else if (r_tent >= TW'(MAX_TENT))
                    w_estado_prox = BLOQUEADO;
                else begin
                    w_estado_prox = ENTRADA;
                    w_falha_prox  = 1'b0;
                end
            end
            DESARMADO: w_estado_prox = DESARMADO;
            BLOQUEADO: w_estado_prox = BLOQUEADO;
            default:   w_estado_prox = ENTRADA;
        endcase
    end

    // Outputs are registered values or are decoded from the state.
    always_comb begin
        bus.indice     = r_indice;
        bus.tentativas = r_tent;
        bus.acerto     = (r_estado == RESULTADO) && !r_falha;
        bus.erro       = (r_estado == RESULTADO) &&  r_falha;
        bus.desarmado  = (r_estado == DESARMADO);
        bus.bloqueado  = (r_estado == BLOQUEADO);
    end
endmodule

// File: tb/tb_comparador_sequencial.sv
`timescale 1ns/1ps
module tb_comparador_sequencial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    comparador_sequencial_if #(.WIDTH(3), .DIGITS(4), .MAX_TENT(3)) bus();

    comparador_sequencial #(
        .WIDTH(3), .DIGITS(4), .MAX_TENT(3), .TIMEOUT_CICLOS(10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ind, input int ten,
                           input int ac, input int er, input int de, input int bl);
        chk({tag, ".indice"},     32'(bus.indice),     32'(ind));
        chk({tag, ".tentativas"}, 32'(bus.tentativas), 32'(ten));
        chk({tag, ".acerto"},     32'(bus.acerto),     32'(ac));
        chk({tag, ".erro"},       32'(bus.erro),       32'(er));
        chk({tag, ".desarmado"},  32'(bus.desarmado),  32'(de));
        chk({tag, ".bloqueado"},  32'(bus.bloqueado),  32'(bl));
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.habilita = 1'b1;
        bus.digito_valido = 1'b0;
        bus.limpar = 1'b0;
        bus.digito = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic strobe(input logic [2:0] d);
        bus.digito = d;
        bus.digito_valido = 1'b1;
        @(negedge clk);
        bus.digito_valido = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic attempt(input logic [2:0] d3);
        strobe(3'd5); strobe(3'd2); strobe(3'd7); strobe(d3);
    endtask

    initial begin
        bus.segredo = 12'h3D5;          // digits 5,2,7,1
        bus.habilita = 1'b1;
        bus.digito = '0;
        bus.digito_valido = 1'b0;
        bus.limpar = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        // Correct code: a single acerto pulse, then disarmed
        strobe(3'd5); strobe(3'd2); strobe(3'd7);
        chk("ok.indice3", 32'(bus.indice), 32'd3);
        strobe(3'd1);
        chk_all("ok.result", 0, 0, 1, 0, 0, 0);
        idle(1);
        chk_all("ok.desarm", 0, 0, 0, 0, 1, 0);
        strobe(3'd5);
        chk_all("ok.absorb", 0, 0, 0, 0, 1, 0);

        // Three wrong attempts lead to lockout
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            attempt(3'd0);
            chk_all($sformatf("bad%0d.result", i), 0, i, 0, 1, 0, 0);
            idle(1);
            chk_all($sformatf("bad%0d.after", i), 0, i, 0, 0, 0, (i == 3) ? 1 : 0);
        end
        attempt(3'd1);
        chk_all("lock.ignored", 0, 3, 0, 0, 0, 1);
        idle(1);
        chk_all("lock.hold", 0, 3, 0, 0, 0, 1);

        // limpar clears a partial attempt, including a sticky mismatch
        do_reset();
        strobe(3'd6);
        bus.limpar = 1'b1;
        @(negedge clk);
        bus.limpar = 1'b0;
        chk("clr1.indice", 32'(bus.indice), 32'd0);
        strobe(3'd5); strobe(3'd2);
        chk("clr2.indice2", 32'(bus.indice), 32'd2);
        bus.limpar = 1'b1;
        strobe(3'd7);
        bus.limpar = 1'b0;
        chk_all("clr2.after", 0, 0, 0, 0, 0, 0);
        attempt(3'd1);
        chk_all("clr.ok", 0, 0, 1, 0, 0, 0);

        // Strobes with habilita=0 are ignored
        do_reset();
        bus.habilita = 1'b0;
        strobe(3'd5);
        chk("hab0.i5", 32'(bus.indice), 32'd0);
        strobe(3'd2);
        chk("hab0.i2", 32'(bus.indice), 32'd0);
        strobe(3'd7);
        chk_all("hab0.i7", 0, 0, 0, 0, 0, 0);
        bus.habilita = 1'b1;
        strobe(3'd1);
        chk("hab1.indice", 32'(bus.indice), 32'd1);

        // Reset in the middle of an attempt and while locked
        do_reset();
        strobe(3'd5); strobe(3'd2);
        chk("mid.indice2", 32'(bus.indice), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all("mid.rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            attempt(3'd0);
            idle(1);
        end
        chk_all("lock2", 0, 3, 0, 0, 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all("lock2.rst", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        attempt(3'd1);
        chk_all("lock2.ok", 0, 0, 1, 0, 0, 0);

        // Idle partial attempt: times out only when the feature is built in
        do_reset();
        strobe(3'd5);
        idle(9);
        chk_all("to.before", 1, 0, 0, 0, 0, 0);
        idle(1);
`ifdef COMPARADOR_TIMEOUT_DIGITO_EN
        chk_all("to.fire", 0, 1, 0, 1, 0, 0);
        idle(1);
        chk_all("to.after", 0, 1, 0, 0, 0, 0);
`else
        chk_all("to.none", 1, 0, 0, 0, 0, 0);
        idle(20);
        chk_all("to.wait", 1, 0, 0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
